// File: rtl/apb_slave_if.sv
// APB completer-side bus bundle.
// Carries setup/access controls, write payload and the completion response.
interface apb_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                      sel;
    logic                      enable;
    logic                      write;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH/8-1:0]   strobe;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      ready;
    logic                      slverr;

    modport master (
        output sel, enable, write, addr, strobe, wdata,
        input  rdata, ready, slverr
    );

    modport slave (
        input  sel, enable, write, addr, strobe, wdata,
        output rdata, ready, slverr
    );
endinterface

// File: rtl/apb_slave.sv
// APB completer: word register file, byte strobes, fixed wait states.
// APB_SLAVE_ERR_EN enables slverr on out-of-range word indices.
module apb_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    apb_slave_if.slave bus
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = ADDR_WIDTH - 2;
    localparam int MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    localparam logic [IW:0]   DEPTH = (IW + 1)'(MEM_DEPTH);
    localparam logic [CW-1:0] WLOAD = CW'(WAIT_CYCLES);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_n;

    logic [CW-1:0]         cnt, cnt_n;
    logic                  take;
    logic                  commit;
    logic [IW-1:0]         idx_q, idx_n;
    logic                  wr_q, wr_n;
    logic                  in_q, in_n;
    logic [SW-1:0]         strb_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  unused_addr;

    assign unused_addr = ^bus.addr[1:0];

    // Index/direction as they will be once this edge's setup is captured,
    // so the registered response lines up with the RESP cycle.
    assign idx_n = take ? bus.addr[ADDR_WIDTH-1:2] : idx_q;
    assign wr_n  = take ? bus.write : wr_q;
    assign in_q  = {1'b0, idx_q} < DEPTH;
    assign in_n  = {1'b0, idx_n} < DEPTH;

    // Next state, wait counter and write-commit decision.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        take    = 1'b0;
        commit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.sel && !bus.enable) begin
                    take    = 1'b1;
                    cnt_n   = WLOAD;
                    state_n = (WAIT_CYCLES > 0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!bus.sel) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - ONE;
                    if (cnt == ONE) state_n = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
                cnt_n   = '0;
                commit  = bus.sel && wr_q && in_q;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Setup-phase capture and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
        end else begin
            cnt <= cnt_n;
            if (take) begin
                idx_q   <= bus.addr[ADDR_WIDTH-1:2];
                wr_q    <= bus.write;
                strb_q  <= bus.strobe;
                wdata_q <= bus.wdata;
            end
        end
    end

    // Register file; strobed lanes commit at the edge ending RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (commit) begin
            for (int b = 0; b < SW; b++) begin
                if (strb_q[b]) begin
                    mem[idx_q[MW-1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Registered completion response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= (state_n == RESP);
            if (state_n == RESP && !wr_n && in_n)
                rdata_q <= mem[idx_n[MW-1:0]];
            else
                rdata_q <= '0;
        end
    end

`ifdef APB_SLAVE_ERR_EN
    logic slverr_q;

    // Error flag for out-of-range completions only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) slverr_q <= 1'b0;
        else     slverr_q <= (state_n == RESP) && !in_n;
    end

    assign bus.slverr = slverr_q;
`else
    assign bus.slverr = 1'b0;
`endif

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_apb_slave.sv
// Bench for apb_slave: three instances with 0, 2 and 3 wait states.
// Scoreboard holds expected latency/rdata/slverr per issued transfer.
module tb_apb_slave;
    typedef struct {
        int          lat;
        logic [31:0] rd;
        logic [31:0] err;
    } exp_t;

`ifdef APB_SLAVE_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        enable;
    logic        write;
    logic [7:0]  addr;
    logic [3:0]  strobe;
    logic [31:0] wdata;
    int          cur;
    int          total = 0;
    int          bad = 0;
    logic [31:0] mdl [3][16];
    exp_t        sb [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : d
        localparam int W = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        apb_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();
        assign bus.sel    = sel && (cur == g);
        assign bus.enable = enable;
        assign bus.write  = write;
        assign bus.addr   = addr;
        assign bus.strobe = strobe;
        assign bus.wdata  = wdata;
        apb_slave #(
            .DATA_WIDTH(32), .ADDR_WIDTH(8),
            .MEM_DEPTH(16), .WAIT_CYCLES(W)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    logic        rdy;
    logic [31:0] rd;
    logic        err;

    assign rdy = (cur == 0) ? d[0].bus.ready :
                 (cur == 1) ? d[1].bus.ready : d[2].bus.ready;
    assign rd  = (cur == 0) ? d[0].bus.rdata :
                 (cur == 1) ? d[1].bus.rdata : d[2].bus.rdata;
    assign err = (cur == 0) ? d[0].bus.slverr :
                 (cur == 1) ? d[1].bus.slverr : d[2].bus.slverr;

    function automatic int wcs(input int k);
        return (k == 0) ? 0 : (k == 1) ? 2 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        sel    = 1'b0;
        enable = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic clr_model();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) mdl[k][i] = '0;
    endtask

    // One transfer on instance cur; leaves sel high for back-to-back use.
    task automatic xfer(input logic wr, input logic [7:0] a,
                        input logic [3:0] s, input logic [31:0] dv);
        exp_t e;
        int   idx;
        bit   inr;
        bit   done;
        idx   = int'(a[7:2]);
        inr   = idx < 16;
        sel    = 1'b1;
        enable = 1'b0;
        write  = wr;
        addr   = a;
        strobe = s;
        wdata  = dv;
        e.lat = wcs(cur) + 1;
        e.err = {31'b0, ERR && !inr};
        e.rd  = (!wr && inr) ? mdl[cur][idx] : 32'h0;
        sb.push_back(e);
        @(posedge clk); #1;
        enable = 1'b1;
        done = 1'b0;
        for (int n = 1; n <= 12 && !done; n++) begin
            @(negedge clk);
            if (rdy) begin
                done = 1'b1;
                e = sb.pop_front();
                chk("latency", n, e.lat);
                chk("rdata", rd, e.rd);
                chk("slverr", {31'b0, err}, e.err);
                if (wr && inr)
                    for (int b = 0; b < 4; b++)
                        if (s[b]) mdl[cur][idx][8*b +: 8] = dv[8*b +: 8];
            end else begin
                chk("wait_rdata", rd, 32'h0);
                chk("wait_slverr", {31'b0, err}, 32'h0);
                @(posedge clk); #1;
            end
        end
        chk("no_timeout", {31'b0, done}, 32'h1);
        if (done) begin
            @(posedge clk); #1;
        end
        enable = 1'b0;
    endtask

    initial begin
        sel = 0; enable = 0; write = 0;
        addr = 0; strobe = 0; wdata = 0;
        cur = 0;
        clr_model();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                cur = k; #0;
                chk("rst_ready", {31'b0, rdy}, 32'h0);
                chk("rst_rdata", rd, 32'h0);
                chk("rst_slverr", {31'b0, err}, 32'h0);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        cur = 0;
        @(posedge clk); #1;

        xfer(0, 8'h00, 4'h0, 32'h0);
        idle();
        xfer(0, 8'h3C, 4'h0, 32'h0);
        idle();

        xfer(1, 8'h04, 4'hF, 32'hDEADBEEF);
        idle();
        xfer(0, 8'h04, 4'h0, 32'h0);
        idle();

        xfer(1, 8'h00, 4'hF, 32'hA0A0A0A0);
        xfer(1, 8'h04, 4'hF, 32'hB1B1B1B1);
        xfer(1, 8'h08, 4'hF, 32'hC2C2C2C2);
        xfer(0, 8'h00, 4'h0, 32'h0);
        xfer(0, 8'h04, 4'h0, 32'h0);
        xfer(0, 8'h08, 4'h0, 32'h0);
        idle();

        cur = 1;
        xfer(1, 8'h08, 4'hF, 32'h11223344);
        idle();
        xfer(1, 8'h08, 4'b0101, 32'hAABBCCDD);
        idle();
        xfer(0, 8'h08, 4'h0, 32'h0);
        idle();
        chk("strobe_model", mdl[1][2], 32'h11BB33DD);

        xfer(1, 8'h40, 4'hF, 32'h12345678);
        idle();
        xfer(0, 8'h40, 4'h0, 32'h0);
        idle();
        xfer(0, 8'h00, 4'h0, 32'h0);
        idle();

        for (int i = 0; i < 8; i++) begin
            logic [7:0] a;
            a = {2'b00, 4'($urandom_range(0, 15)), 2'b00};
            xfer(1, a, 4'($urandom), $urandom);
            xfer(0, a, 4'h0, 32'h0);
        end
        idle();

        cur = 2;
        sel = 1'b1; enable = 1'b0; write = 1'b1;
        addr = 8'h0C; strobe = 4'hF; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        chk("abort_w1", {31'b0, rdy}, 32'h0);
        @(posedge clk); #1;
        sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_ready", {31'b0, rdy}, 32'h0);
            @(posedge clk); #1;
        end
        enable = 1'b0;
        xfer(0, 8'h0C, 4'h0, 32'h0);
        idle();

        sel = 1'b1; enable = 1'b0; write = 1'b1;
        addr = 8'h0C; strobe = 4'hF; wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", {31'b0, rdy}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        clr_model();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_after", {31'b0, rdy}, 32'h0);
            @(posedge clk); #1;
        end
        idle();
        xfer(0, 8'h0C, 4'h0, 32'h0);
        idle();
        cur = 0;
        xfer(0, 8'h04, 4'h0, 32'h0);
        idle();

        chk("sb_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
